// File: rtl/multi_digit_counter_if.sv
// rtl/multi_digit_counter_if.sv - control and count signals of the cascaded digit counter
interface multi_digit_counter_if #(
    parameter int DIGITS  = 2,
    parameter int DIGIT_W = 4
);
    logic                        en;
    logic                        up_dn;
    logic                        clear;
    logic                        load;
    logic [DIGITS*DIGIT_W-1:0]   load_value;
    logic [DIGITS*DIGIT_W-1:0]   digits_out;
    logic                        carry_out;

    modport master (
        output en, up_dn, clear, load, load_value,
        input  digits_out, carry_out
    );

    modport slave (
        input  en, up_dn, clear, load, load_value,
        output digits_out, carry_out
    );
endinterface

// File: rtl/multi_digit_counter.sv
// rtl/multi_digit_counter.sv - prescaled cascaded modulo counter; define MULTI_DIGIT_COUNTER_DOWN_EN to honour up_dn
module multi_digit_counter #(
    parameter int DIGITS   = 2,
    parameter int DIGIT_W  = 4,
    parameter int MODULUS  = 10,
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               reset,
    multi_digit_counter_if.slave bus
);
    localparam int                 PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]    PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [DIGIT_W-1:0] D_MAX   = DIGIT_W'(MODULUS - 1);

    logic [DIGITS-1:0][DIGIT_W-1:0] cnt;
    logic [DIGITS-1:0][DIGIT_W-1:0] step_val;
    logic [DIGITS-1:0][DIGIT_W-1:0] load_val;
    logic [PS_W-1:0]                pre;
    logic                           carry_q;
    logic                           wrap;
    logic                           step;

    assign step = bus.en && (pre == PS_LAST);

`ifndef MULTI_DIGIT_COUNTER_DOWN_EN
    logic unused_up_dn;
    assign unused_up_dn = bus.up_dn;
`endif

    // wrap doubles as the ripple enable: it stays set while every lower digit rolled over
    always_comb begin
        step_val = cnt;
        wrap     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (wrap) begin
`ifdef MULTI_DIGIT_COUNTER_DOWN_EN
                if (!bus.up_dn) begin
                    if (cnt[i] == '0) begin
                        step_val[i] = D_MAX;
                    end else begin
                        step_val[i] = cnt[i] - 1'b1;
                        wrap        = 1'b0;
                    end
                end else
`endif
                begin
                    if (cnt[i] == D_MAX) begin
                        step_val[i] = '0;
                    end else begin
                        step_val[i] = cnt[i] + 1'b1;
                        wrap        = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        load_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_val[i] = bus.load_value[i*DIGIT_W +: DIGIT_W];
            if (load_val[i] > D_MAX) begin
                load_val[i] = D_MAX;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            pre     <= '0;
            carry_q <= 1'b0;
        end else if (bus.clear) begin
            cnt     <= '0;
            pre     <= '0;
            carry_q <= 1'b0;
        end else if (bus.load) begin
            cnt     <= load_val;
            pre     <= '0;
            carry_q <= 1'b0;
        end else if (step) begin
            cnt     <= step_val;
            pre     <= '0;
            carry_q <= wrap;
        end else begin
            if (bus.en) begin
                pre <= pre + PS_W'(1);
            end
            carry_q <= 1'b0;
        end
    end

    assign bus.digits_out = cnt;
    assign bus.carry_out  = carry_q;
endmodule

// File: tb/tb_multi_digit_counter.sv
// tb/tb_multi_digit_counter.sv - model-checked bench for two counters, PRESCALE 1 and 3
module tb_multi_digit_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    int m_val   [2];
    int m_phase [2];
    bit m_carry [2];
    int ps      [2];

    multi_digit_counter_if #(.DIGITS(2), .DIGIT_W(4)) bus_a ();
    multi_digit_counter_if #(.DIGITS(2), .DIGIT_W(4)) bus_b ();

    assign bus_a.en = en;         assign bus_b.en = en;
    assign bus_a.up_dn = up_dn;   assign bus_b.up_dn = up_dn;
    assign bus_a.clear = clear;   assign bus_b.clear = clear;
    assign bus_a.load = load;     assign bus_b.load = load;
    assign bus_a.load_value = load_value;
    assign bus_b.load_value = load_value;

    multi_digit_counter #(.DIGITS(2), .DIGIT_W(4), .MODULUS(10), .PRESCALE(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    multi_digit_counter #(.DIGITS(2), .DIGIT_W(4), .MODULUS(10), .PRESCALE(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;

    function automatic int to_bcd(int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    function automatic int clamp_load(logic [7:0] lv);
        int hi;
        int lo;
        hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
        lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
        return hi * 10 + lo;
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Counter value held as an integer 0..99; a step is +/-1 modulo 100.
    always @(posedge clk or posedge reset) begin
        bit go_up;
`ifdef MULTI_DIGIT_COUNTER_DOWN_EN
        go_up = up_dn;
`else
        go_up = 1'b1;
`endif
        for (int k = 0; k < 2; k++) begin
            if (reset || clear) begin
                m_val[k] <= 0; m_phase[k] <= 0; m_carry[k] <= 1'b0;
            end else if (load) begin
                m_val[k] <= clamp_load(load_value); m_phase[k] <= 0; m_carry[k] <= 1'b0;
            end else if (en && m_phase[k] == ps[k] - 1) begin
                m_phase[k] <= 0;
                if (go_up) begin
                    m_val[k] <= (m_val[k] + 1) % 100; m_carry[k] <= (m_val[k] == 99);
                end else begin
                    m_val[k] <= (m_val[k] + 99) % 100; m_carry[k] <= (m_val[k] == 0);
                end
            end else begin
                if (en) m_phase[k] <= m_phase[k] + 1;
                m_carry[k] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("model_a_digits", int'(bus_a.digits_out), to_bcd(m_val[0]));
            check("model_a_carry",  int'(bus_a.carry_out),  int'(m_carry[0]));
            check("model_b_digits", int'(bus_b.digits_out), to_bcd(m_val[1]));
            check("model_b_carry",  int'(bus_b.carry_out),  int'(m_carry[1]));
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        ps[0] = 1;
        ps[1] = 3;
        tick(2);
        reset = 1'b0;
        check("reset_a", int'(bus_a.digits_out), 'h00);
        check("reset_carry", int'(bus_a.carry_out), 0);

        en = 1'b1; up_dn = 1'b1;
        tick(9);  check("up_09", int'(bus_a.digits_out), 'h09);
        tick(1);  check("up_10", int'(bus_a.digits_out), 'h10);
        tick(9);  check("up_19", int'(bus_a.digits_out), 'h19);
        tick(1);  check("up_20", int'(bus_a.digits_out), 'h20);
        tick(79); check("up_99", int'(bus_a.digits_out), 'h99);
        check("up_99_carry", int'(bus_a.carry_out), 0);
        tick(1);  check("wrap_00", int'(bus_a.digits_out), 'h00);
        check("wrap_carry", int'(bus_a.carry_out), 1);
        tick(1);  check("wrap_carry_drop", int'(bus_a.carry_out), 0);

        tick(46); check("at_47", int'(bus_a.digits_out), 'h47);
        #2 reset = 1'b1;
        #1;
        check("async_reset_a", int'(bus_a.digits_out), 'h00);
        check("async_reset_carry", int'(bus_a.carry_out), 0);
        check("async_reset_b", int'(bus_b.digits_out), 'h00);
        @(negedge clk);
        reset = 1'b0;
        tick(1); check("resume_a", int'(bus_a.digits_out), 'h01);
        check("pre_b_edge1", int'(bus_b.digits_out), 'h00);
        tick(1); check("pre_b_edge2", int'(bus_b.digits_out), 'h00);
        tick(1); check("pre_b_edge3", int'(bus_b.digits_out), 'h01);
        tick(1);
        en = 1'b0; tick(2);
        check("pre_hold", int'(bus_b.digits_out), 'h01);
        en = 1'b1; tick(1);
        check("pre_delayed", int'(bus_b.digits_out), 'h01);
        tick(1); check("pre_step", int'(bus_b.digits_out), 'h02);

        load = 1'b1; load_value = 8'h57;
        tick(1); check("load_57", int'(bus_a.digits_out), 'h57);
        load_value = 8'hF3;
        tick(1); check("load_clamp", int'(bus_a.digits_out), 'h93);
        clear = 1'b1;
        tick(1); check("clear_over_load", int'(bus_a.digits_out), 'h00);
        clear = 1'b0; load_value = 8'h99;
        tick(1); check("load_99", int'(bus_a.digits_out), 'h99);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("hold_99", int'(bus_a.digits_out), 'h99);
            check("hold_no_carry", int'(bus_a.carry_out), 0);
        end

        load = 1'b1; load_value = 8'h01;
        tick(1);
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        tick(1);
`ifdef MULTI_DIGIT_COUNTER_DOWN_EN
        check("down_00", int'(bus_a.digits_out), 'h00);
        tick(1);
        check("down_wrap_99", int'(bus_a.digits_out), 'h99);
        check("down_wrap_carry", int'(bus_a.carry_out), 1);
`else
        check("no_down_02", int'(bus_a.digits_out), 'h02);
        tick(1);
        check("no_down_03", int'(bus_a.digits_out), 'h03);
        check("no_down_carry", int'(bus_a.carry_out), 0);
`endif

        for (int i = 0; i < 300; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            up_dn = $urandom_range(0, 1) == 1;
            load  = ($urandom_range(0, 15) == 0);
            clear = ($urandom_range(0, 31) == 0);
            load_value = 8'($urandom);
            tick(1);
        end
        en = 1'b0; load = 1'b0; clear = 1'b0;
        tick(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
